// File: rtl/bg_bank_responder_pkg.sv
// Shared bus geometry and request decode for the bank-group responder.
// The field positions below describe the default bus; parameterised instances derive their own.
package bg_bank_responder_pkg;

  localparam int A_W = 10;
  localparam int D_W = 32;

  localparam int L_C_bus = A_W + D_W + 2;
  localparam int C_L_bus = D_W + 1;

  localparam int WEN_POS  = L_C_bus - 1;
  localparam int REN_POS  = L_C_bus - 2;
  localparam int A_MSB    = A_W + D_W - 1;
  localparam int A_LSB    = D_W;
  localparam int DATA_MSB = D_W - 1;
  localparam int DATA_LSB = 0;

  localparam int R_VALID_POS = C_L_bus - 1;
  localparam int R_DATA_MSB  = D_W - 1;

  localparam int READ_LAT_MIN = 1;
  localparam int READ_LAT_MAX = 4;

  typedef enum logic [1:0] {
    OP_IDLE     = 2'd0,
    OP_WRITE    = 2'd1,
    OP_READ     = 2'd2,
    OP_CONFLICT = 2'd3
  } op_t;

  // Read wins the shared address, so a request with both enables is a read plus a dropped write.
  function automatic op_t decode_op(input logic ren, input logic wen);
    op_t op;
    op = OP_IDLE;
    if (ren && wen)  op = OP_CONFLICT;
    else if (ren)    op = OP_READ;
    else if (wen)    op = OP_WRITE;
    return op;
  endfunction

endpackage

// File: rtl/bg_rd_pipe.sv
// Fixed-depth {valid, data} shift pipeline that delays bank read results.
// STAGES may be zero, in which case the input is passed straight through.
module bg_rd_pipe #(
  parameter int D_W    = 32,
  parameter int STAGES = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  input  logic [D_W-1:0] in_data,
  output logic           out_valid,
  output logic [D_W-1:0] out_data,
  output logic           busy
);

  generate
    if (STAGES == 0) begin : g_bypass
      assign out_valid = in_valid;
      assign out_data  = in_data;
      assign busy      = 1'b0;
    end else begin : g_pipe
      logic [STAGES-1:0] vld;
      logic [D_W-1:0]    dat [STAGES];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld <= '0;
          for (int i = 0; i < STAGES; i++) dat[i] <= '0;
        end else begin
          vld[0] <= in_valid;
          dat[0] <= in_data;
          for (int i = 1; i < STAGES; i++) begin
            vld[i] <= vld[i-1];
            dat[i] <= dat[i-1];
          end
        end
      end

      assign out_valid = vld[STAGES-1];
      assign out_data  = dat[STAGES-1];
      assign busy      = |vld;
    end
  endgenerate

endmodule

// File: rtl/bg_bank_responder.sv
// Bank-group endpoint: decodes one request per cycle, owns the word bank and
// returns read data READ_LAT edges later with saturating access statistics.
module bg_bank_responder #(
  parameter int A_W      = bg_bank_responder_pkg::A_W,
  parameter int D_W      = bg_bank_responder_pkg::D_W,
  parameter int READ_LAT = 2,
  parameter int CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [A_W+D_W+1:0]   BG_in,
  output logic [D_W:0]         R_reponse,
  output logic                 busy,
  output logic [CNT_W-1:0]     conflict_cnt,
  output logic [CNT_W-1:0]     rd_cnt,
  output logic [CNT_W-1:0]     wr_cnt
);
  import bg_bank_responder_pkg::*;

  localparam int WEN_BIT = A_W + D_W + 1;
  localparam int REN_BIT = A_W + D_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic           wen;
  logic           ren;
  logic [A_W-1:0] addr;
  logic [D_W-1:0] wdata;
  op_t            op;

  assign wen   = BG_in[WEN_BIT];
  assign ren   = BG_in[REN_BIT];
  assign addr  = BG_in[A_W+D_W-1:D_W];
  assign wdata = BG_in[D_W-1:0];
  assign op    = decode_op(ren, wen);

  logic           rd_issue;
  logic           wr_commit;
  logic           wr_drop;

  assign rd_issue  = (op == OP_READ) || (op == OP_CONFLICT);
  assign wr_commit = (op == OP_WRITE);
  assign wr_drop   = (op == OP_CONFLICT);

  // Bank and first read stage; left unreset so the array maps onto a plain RAM.
  logic [D_W-1:0] mem [2**A_W];
  logic [D_W-1:0] s1_data;
  logic           s1_valid;

  always_ff @(posedge clk) begin
    if (wr_commit) mem[addr] <= wdata;
    if (rd_issue)  s1_data   <= mem[addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s1_valid <= 1'b0;
    else        s1_valid <= rd_issue;
  end

  logic           out_valid;
  logic [D_W-1:0] out_data;
  logic           pipe_busy;

  bg_rd_pipe #(
    .D_W    (D_W),
    .STAGES (READ_LAT - 1)
  ) u_rd_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s1_valid),
    .in_data   (s1_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .busy      (pipe_busy)
  );

  // Data is forced to zero outside the valid cycle so stale stage contents never leak out.
  assign R_reponse = {out_valid, (out_valid ? out_data : {D_W{1'b0}})};
  assign busy      = s1_valid | pipe_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt       <= '0;
      wr_cnt       <= '0;
      conflict_cnt <= '0;
    end else begin
      if (rd_issue  && (rd_cnt       != CNT_MAX)) rd_cnt       <= rd_cnt + 1'b1;
      if (wr_commit && (wr_cnt       != CNT_MAX)) wr_cnt       <= wr_cnt + 1'b1;
      if (wr_drop   && (conflict_cnt != CNT_MAX)) conflict_cnt <= conflict_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_bg_bank_responder.sv
// Bench for bg_bank_responder: a READ_LAT=2 main instance plus READ_LAT=1 and
// READ_LAT=4 instances with 4-bit counters, all fed from the same request bus.
module tb_bg_bank_responder;

  localparam int A_W = 10;
  localparam int D_W = 32;
  localparam int L_W = A_W + D_W + 2;

  logic           clk;
  logic           rst_n;
  logic [L_W-1:0] bg_in;

  logic [D_W:0]   resp_m, resp_1, resp_4;
  logic           busy_m, busy_1, busy_4;
  logic [15:0]    cf_m, rd_m, wr_m;
  logic [3:0]     cf_1, rd_1, wr_1;
  logic [3:0]     cf_4, rd_4, wr_4;

  bg_bank_responder #(.A_W(A_W), .D_W(D_W), .READ_LAT(2), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .BG_in(bg_in), .R_reponse(resp_m), .busy(busy_m),
    .conflict_cnt(cf_m), .rd_cnt(rd_m), .wr_cnt(wr_m)
  );

  bg_bank_responder #(.A_W(A_W), .D_W(D_W), .READ_LAT(1), .CNT_W(4)) dut_l1 (
    .clk(clk), .rst_n(rst_n), .BG_in(bg_in), .R_reponse(resp_1), .busy(busy_1),
    .conflict_cnt(cf_1), .rd_cnt(rd_1), .wr_cnt(wr_1)
  );

  bg_bank_responder #(.A_W(A_W), .D_W(D_W), .READ_LAT(4), .CNT_W(4)) dut_l4 (
    .clk(clk), .rst_n(rst_n), .BG_in(bg_in), .R_reponse(resp_4), .busy(busy_4),
    .conflict_cnt(cf_4), .rd_cnt(rd_4), .wr_cnt(wr_4)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Scoreboard counts of what the bus has asked for since the last reset.
  int n_rd = 0;
  int n_wr = 0;
  int n_cf = 0;

  typedef struct {
    logic         wen;
    logic         ren;
    logic [9:0]   a;
    logic [31:0]  data;
    logic [32:0]  exp_resp;
    logic         exp_busy;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int c, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (c > mx) ? mx : c;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // driver: present one request, account for it in the scoreboard, advance one edge
  task automatic drive(input logic w, input logic r, input logic [9:0] a, input logic [31:0] d);
    bg_in = {w, r, a, d};
    if (r) n_rd++;
    if (w && !r) n_wr++;
    if (w && r) n_cf++;
    step();
  endtask

  task automatic check_cnts(input string tag);
    check({tag, ".rd_cnt"},       64'(rd_m), 64'(sat(n_rd, 16)));
    check({tag, ".wr_cnt"},       64'(wr_m), 64'(sat(n_wr, 16)));
    check({tag, ".conflict_cnt"}, 64'(cf_m), 64'(sat(n_cf, 16)));
    check({tag, ".l1.rd_cnt"},    64'(rd_1), 64'(sat(n_rd, 4)));
    check({tag, ".l1.wr_cnt"},    64'(wr_1), 64'(sat(n_wr, 4)));
    check({tag, ".l4.conflict"},  64'(cf_4), 64'(sat(n_cf, 4)));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".resp_m"}, 64'(resp_m), 64'd0);
    check({tag, ".resp_1"}, 64'(resp_1), 64'd0);
    check({tag, ".resp_4"}, 64'(resp_4), 64'd0);
    check({tag, ".busy"},   64'({busy_m, busy_1, busy_4}), 64'd0);
    check({tag, ".cnts"},   64'({cf_m, rd_m, wr_m, cf_1, rd_1, wr_1, cf_4, rd_4, wr_4}), 64'd0);
  endtask

  task automatic add_row(input logic w, input logic r, input logic [9:0] a, input logic [31:0] d,
                         input logic [32:0] er, input logic eb);
    vec_t v;
    v.wen = w; v.ren = r; v.a = a; v.data = d; v.exp_resp = er; v.exp_busy = eb;
    vecs.push_back(v);
  endtask

  // Enables must never be unknown while the block is out of reset.
  always @(posedge clk) begin
    if (rst_n && $isunknown(bg_in[L_W-1:L_W-2])) begin
      errors++;
      $display("FAIL protocol_x_on_enables bg_in=%0h", bg_in);
    end
  end

  initial begin
    logic [31:0] d;
    logic [32:0] e1, e4, em;

    rst_n = 1'b0;
    bg_in = '0;

    // Reset held for 3 cycles, then idle
    for (int i = 0; i < 3; i++) begin
      step();
      check_all_zero("reset_hold");
    end
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 10'h0, 32'h0);
      check_all_zero("idle");
    end

    // Table: write-then-read, streaming, collision (main instance has READ_LAT=2)
    add_row(1, 0, 10'h005, 32'hDEADBEEF, 33'h0, 0);
    add_row(0, 1, 10'h005, 32'h0,        33'h0, 1);
    add_row(0, 0, 10'h000, 32'h0,        {1'b1, 32'hDEADBEEF}, 1);
    add_row(0, 0, 10'h000, 32'h0,        33'h0, 0);
    for (int a = 0; a < 8; a++) add_row(1, 0, 10'(a), 32'(a) * 32'h11111111, 33'h0, 0);
    for (int a = 0; a < 8; a++)
      add_row(0, 1, 10'(a), 32'h0,
              (a == 0) ? 33'h0 : {1'b1, 32'(a - 1) * 32'h11111111}, 1);
    add_row(0, 0, 10'h000, 32'h0, {1'b1, 32'h77777777}, 1);
    add_row(0, 0, 10'h000, 32'h0, 33'h0, 0);
    add_row(1, 0, 10'h3FF, 32'h12345678, 33'h0, 0);
    add_row(1, 1, 10'h3FF, 32'hCAFEF00D, 33'h0, 1);
    add_row(0, 1, 10'h3FF, 32'h0,        {1'b1, 32'h12345678}, 1);
    add_row(0, 0, 10'h000, 32'h0,        {1'b1, 32'h12345678}, 1);
    add_row(0, 0, 10'h000, 32'h0,        33'h0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].wen, vecs[i].ren, vecs[i].a, vecs[i].data);
      check($sformatf("row%0d.resp", i), 64'(resp_m), 64'(vecs[i].exp_resp));
      check($sformatf("row%0d.busy", i), 64'(busy_m), 64'(vecs[i].exp_busy));
      check_cnts($sformatf("row%0d", i));
    end

    // Reset mid-flight: two reads, then asynchronous reset before READ_LAT=4 responds
    drive(0, 1, 10'h005, 32'h0);
    drive(0, 1, 10'h005, 32'h0);
    bg_in = '0;
    #3;
    rst_n = 1'b0;
    #1;
    n_rd = 0; n_wr = 0; n_cf = 0;
    check_all_zero("async_reset");
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, 10'h0, 32'h0);
      check("post_reset.no_valid", 64'({resp_m[32], resp_1[32], resp_4[32]}), 64'd0);
    end

    // Saturation of the 4-bit counters, 16-bit counter keeps counting
    for (int i = 0; i < 20; i++) drive(0, 1, 10'(i % 8), 32'h0);
    check("sat.l1.rd_cnt", 64'(rd_1), 64'd15);
    check("sat.l4.rd_cnt", 64'(rd_4), 64'd15);
    check("sat.main.rd_cnt", 64'(rd_m), 64'd20);
    for (int i = 0; i < 6; i++) drive(0, 0, 10'h0, 32'h0);
    check("sat.drained.busy", 64'({busy_m, busy_1, busy_4}), 64'd0);

    // Latency sweep: k counts edges since the read appeared on the bus
    d = 32'hA5A50001;
    drive(1, 0, 10'h100, d);
    for (int k = 1; k <= 6; k++) begin
      if (k == 1) drive(0, 1, 10'h100, 32'h0);
      else        drive(0, 0, 10'h000, 32'h0);
      e1 = (k == 1) ? {1'b1, d} : 33'h0;
      em = (k == 2) ? {1'b1, d} : 33'h0;
      e4 = (k == 4) ? {1'b1, d} : 33'h0;
      check($sformatf("lat1.k%0d", k), 64'(resp_1), 64'(e1));
      check($sformatf("lat2.k%0d", k), 64'(resp_m), 64'(em));
      check($sformatf("lat4.k%0d", k), 64'(resp_4), 64'(e4));
    end
    check_cnts("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
